// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// switch_allocator : per-output round-robin packet allocator driving the
//                    one-hot selects of a 5x5 registered crossbar.
// Revision 1.0
// ============================================================================
module switch_allocator #(
    parameter int NPORT   = 5,
    parameter int PTR_RST = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NPORT-1:0]   req_i,
    input  logic [3*NPORT-1:0] dst_i,
    input  logic [NPORT-1:0]   tail_i,
    input  logic [NPORT-1:0]   out_rdy_i,
    output logic [NPORT-1:0]   gnt_o,
    output logic [NPORT-1:0]   sel0_o,
    output logic [NPORT-1:0]   sel1_o,
    output logic [NPORT-1:0]   sel2_o,
    output logic [NPORT-1:0]   sel3_o,
    output logic [NPORT-1:0]   sel4_o,
    output logic [NPORT-1:0]   out_vld_o
);

    localparam logic [2:0] c_PTR_RST = 3'(PTR_RST);

    logic [NPORT-1:0] locked_q, locked_d;
    logic [2:0]       owner_q [NPORT];
    logic [2:0]       owner_d [NPORT];
    logic [2:0]       ptr_q   [NPORT];
    logic [2:0]       ptr_d   [NPORT];
    logic [NPORT-1:0] out_vld_q, out_vld_d;

    logic [NPORT-1:0] owns_w;
    logic [NPORT-1:0] xfer_w;
    logic [NPORT-1:0] sel_w  [NPORT];
    logic [NPORT-1:0] elig_w [NPORT];

    // An input may hold at most one output; holders are excluded from arbitration.
    always_comb begin
        owns_w = '0;
        for (int j = 0; j < NPORT; j++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (locked_q[j] && (owner_q[j] == 3'(i))) begin
                    owns_w[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NPORT; j++) begin
            for (int i = 0; i < NPORT; i++) begin
                elig_w[j][i] = req_i[i] && (dst_i[3*i +: 3] == 3'(j)) && !owns_w[i];
            end
        end
    end

    always_comb begin
        gnt_o  = '0;
        xfer_w = '0;
        for (int j = 0; j < NPORT; j++) begin
            sel_w[j] = '0;
            for (int i = 0; i < NPORT; i++) begin
                if (locked_q[j] && (owner_q[j] == 3'(i))) begin
                    sel_w[j][i] = 1'b1;
                    xfer_w[j]   = req_i[i] && out_rdy_i[j];
                    gnt_o[i]    = gnt_o[i] | (req_i[i] && out_rdy_i[j]);
                end
            end
        end
    end

    always_comb begin
        int   idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        locked_d  = locked_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        out_vld_d = xfer_w;
        for (int j = 0; j < NPORT; j++) begin
            if (locked_q[j]) begin
                if (xfer_w[j] && |(sel_w[j] & tail_i)) begin
                    locked_d[j] = 1'b0;
                end
            end else begin
                found = 1'b0;
                // Search ptr, ptr+1, ... modulo NPORT; the first eligible input wins.
                for (int k = 0; k < NPORT; k++) begin
                    idx = int'(ptr_q[j]) + k;
                    if (idx >= NPORT) begin
                        idx = idx - NPORT;
                    end
                    for (int i = 0; i < NPORT; i++) begin
                        if ((idx == i) && !found && elig_w[j][i]) begin
                            found       = 1'b1;
                            locked_d[j] = 1'b1;
                            owner_d[j]  = 3'(i);
                            ptr_d[j]    = (i == NPORT - 1) ? 3'd0 : 3'(i + 1);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_q  <= '0;
            out_vld_q <= '0;
            for (int j = 0; j < NPORT; j++) begin
                owner_q[j] <= '0;
                ptr_q[j]   <= c_PTR_RST;
            end
        end else begin
            locked_q  <= locked_d;
            out_vld_q <= out_vld_d;
            for (int j = 0; j < NPORT; j++) begin
                owner_q[j] <= owner_d[j];
                ptr_q[j]   <= ptr_d[j];
            end
        end
    end

    assign sel0_o    = sel_w[0];
    assign sel1_o    = sel_w[1];
    assign sel2_o    = sel_w[2];
    assign sel3_o    = sel_w[3];
    assign sel4_o    = sel_w[4];
    assign out_vld_o = out_vld_q;

endmodule
`default_nettype wire
